// File: rtl/lfsr1_checker_if.sv
// lfsr1_checker_if: data/control/status bundle between a PRBS word source and lfsr1_checker
//   i_data_in    received LFSR word (source -> checker)
//   i_data_valid i_data_in is sampled on this clock edge
//   i_clr_cnt    synchronous clear of both counters
//   o_locked     checker is in LOCKED
//   o_err_pulse  one-cycle flag for a mismatched word while locked
//   o_err_cnt    saturating count of mismatched words while locked
//   o_word_cnt   saturating count of valid words checked while locked
interface lfsr1_checker_if #(
   parameter int CNT_W = 16
) ();
   logic [15:0]      i_data_in;
   logic             i_data_valid;
   logic             i_clr_cnt;
   logic             o_locked;
   logic             o_err_pulse;
   logic [CNT_W-1:0] o_err_cnt;
   logic [CNT_W-1:0] o_word_cnt;
   modport master (
      output i_data_in, i_data_valid, i_clr_cnt,
      input  o_locked, o_err_pulse, o_err_cnt, o_word_cnt
   );
   modport slave (
      input  i_data_in, i_data_valid, i_clr_cnt,
      output o_locked, o_err_pulse, o_err_cnt, o_word_cnt
   );
endinterface

// File: rtl/lfsr1_checker.sv
// lfsr1_checker: self-synchronising receive checker for the 16-bit lfsr1 PRBS stream
//   clk    rising-edge clock
//   resetn asynchronous active-low reset
//   bus    lfsr1_checker_if slave: word/valid/clear in, lock/error status and counters out
module lfsr1_checker #(
   parameter logic [15:0] TAPS       = 16'hB400,
   parameter int          LOCK_CNT   = 4,
   parameter int          UNLOCK_CNT = 8,
   parameter int          CNT_W      = 16
) (
   input logic            clk,
   input logic            resetn,
   lfsr1_checker_if.slave bus
);
   typedef enum logic [1:0] {SEEK, VERIFY, LOCKED} state_t;
   localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
   localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);
   state_t           r_state, w_state_nx;
   logic [15:0]      r_exp, w_exp_nx, w_f_in, w_f_exp;
   logic [3:0]       r_match, w_match_nx, r_bad, w_bad_nx;
   logic             r_locked, r_err_pulse, w_err_nx, w_inc_word, w_inc_err, w_hit, w_nz;
   logic [CNT_W-1:0] r_err_cnt, r_word_cnt;
   assign w_f_in  = {bus.i_data_in[14:0], ^(bus.i_data_in & TAPS)};
   assign w_f_exp = {r_exp[14:0], ^(r_exp & TAPS)};
   assign w_hit   = bus.i_data_in == r_exp;
   assign w_nz    = bus.i_data_in != 16'h0;
   always_comb begin
      w_state_nx = r_state;
      w_exp_nx   = r_exp;
      w_match_nx = r_match;
      w_bad_nx   = r_bad;
      w_err_nx   = 1'b0;
      w_inc_word = 1'b0;
      w_inc_err  = 1'b0;
      if (bus.i_data_valid) begin
         case (r_state)
            SEEK: begin
               // the all-zero word is the LFSR lock-up state and can never seed a valid sequence
               if (w_nz) begin
                  w_exp_nx   = w_f_in;
                  w_match_nx = 4'd0;
                  w_state_nx = VERIFY;
               end
            end
            VERIFY: begin
               if (w_hit) begin
                  w_exp_nx   = w_f_exp;
                  w_match_nx = r_match + 4'd1;
                  w_state_nx = (r_match + 4'd1 == LOCK_N) ? LOCKED : VERIFY;
               end else begin
                  w_match_nx = 4'd0;
                  w_exp_nx   = w_nz ? w_f_in : r_exp;
                  w_state_nx = w_nz ? VERIFY : SEEK;
               end
            end
            LOCKED: begin
               // flywheel: keep stepping the local LFSR so isolated bit errors do not reseed it
               w_exp_nx   = w_f_exp;
               w_inc_word = 1'b1;
               w_inc_err  = !w_hit;
               w_err_nx   = !w_hit;
               w_bad_nx   = w_hit ? 4'd0 : r_bad + 4'd1;
               if (!w_hit && r_bad + 4'd1 == UNLOCK_N) begin
                  w_bad_nx   = 4'd0;
                  w_state_nx = SEEK;
               end
            end
            default: w_state_nx = SEEK;
         endcase
      end
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= SEEK;
         r_exp       <= 16'h0;
         r_match     <= 4'd0;
         r_bad       <= 4'd0;
         r_locked    <= 1'b0;
         r_err_pulse <= 1'b0;
         r_err_cnt   <= '0;
         r_word_cnt  <= '0;
      end else begin
         r_state     <= w_state_nx;
         r_exp       <= w_exp_nx;
         r_match     <= w_match_nx;
         r_bad       <= w_bad_nx;
         r_locked    <= w_state_nx == LOCKED;
         r_err_pulse <= w_err_nx;
         r_err_cnt   <= bus.i_clr_cnt ? '0 : (w_inc_err && !(&r_err_cnt)) ? r_err_cnt + CNT_W'(1) : r_err_cnt;
         r_word_cnt  <= bus.i_clr_cnt ? '0 : (w_inc_word && !(&r_word_cnt)) ? r_word_cnt + CNT_W'(1) : r_word_cnt;
      end
   end
   assign bus.o_locked    = r_locked;
   assign bus.o_err_pulse = r_err_pulse;
   assign bus.o_err_cnt   = r_err_cnt;
   assign bus.o_word_cnt  = r_word_cnt;
endmodule

// File: tb/tb_lfsr1_checker.sv
// tb_lfsr1_checker: directed scoreboard bench for lfsr1_checker
module tb_lfsr1_checker;
   localparam int LOCK = 4;
   localparam int UNLOCK = 8;
   localparam int MAXC = 65535;
   typedef struct packed {
      logic        lk;
      logic        ep;
      logic [15:0] ec;
      logic [15:0] wc;
   } exp_t;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int n_vec = 0;
   int n_err = 0;
   exp_t sb[$];
   int m_state, m_match, m_bad, m_err, m_word;
   logic [15:0] m_exp, g;
   logic m_pulse;
   lfsr1_checker_if #(.CNT_W(16)) bus ();
   lfsr1_checker dut (.clk(clk), .resetn(resetn), .bus(bus.slave));
   always #5 clk = ~clk;
   function automatic logic [15:0] f(input logic [15:0] s);
      return {s[14:0], ^(s & 16'hB400)};
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask
   task automatic model_reset();
      m_state = 0; m_match = 0; m_bad = 0; m_err = 0; m_word = 0; m_exp = 16'h0; m_pulse = 1'b0;
      sb.delete();
   endtask
   task automatic model(input logic [15:0] d, input logic v, input logic c);
      m_pulse = 1'b0;
      if (v) begin
         if (m_state == 0) begin
            if (d != 16'h0) begin m_exp = f(d); m_match = 0; m_state = 1; end
         end else if (m_state == 1) begin
            if (d == m_exp) begin
               m_exp = f(m_exp); m_match++;
               if (m_match == LOCK) m_state = 2;
            end else begin
               m_match = 0;
               if (d == 16'h0) m_state = 0;
               else m_exp = f(d);
            end
         end else begin
            if (m_word < MAXC) m_word++;
            if (d == m_exp) m_bad = 0;
            else begin
               if (m_err < MAXC) m_err++;
               m_pulse = 1'b1;
               m_bad++;
               if (m_bad == UNLOCK) begin m_state = 0; m_bad = 0; end
            end
            m_exp = f(m_exp);
         end
      end
      if (c) begin m_err = 0; m_word = 0; end
   endtask
   task automatic step(input logic [15:0] d, input logic v, input logic c);
      exp_t e;
      bus.i_data_in = d; bus.i_data_valid = v; bus.i_clr_cnt = c;
      model(d, v, c);
      sb.push_back({(m_state == 2), m_pulse, 16'(m_err), 16'(m_word)});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("sb_locked", 32'(bus.o_locked), 32'(e.lk));
      chk("sb_err_pulse", 32'(bus.o_err_pulse), 32'(e.ep));
      chk("sb_err_cnt", 32'(bus.o_err_cnt), 32'(e.ec));
      chk("sb_word_cnt", 32'(bus.o_word_cnt), 32'(e.wc));
   endtask
   task automatic good(input int n);
      for (int i = 0; i < n; i++) begin step(g, 1'b1, 1'b0); g = f(g); end
   endtask
   task automatic do_reset();
      resetn = 1'b0;
      bus.i_data_in = 16'h0; bus.i_data_valid = 1'b0; bus.i_clr_cnt = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_locked", 32'(bus.o_locked), 0);
      chk("rst_err_pulse", 32'(bus.o_err_pulse), 0);
      chk("rst_err_cnt", 32'(bus.o_err_cnt), 0);
      chk("rst_word_cnt", 32'(bus.o_word_cnt), 0);
      resetn = 1'b1;
   endtask
   initial begin
      do_reset();
      // lock from seed 1, then count 256 locked words
      g = 16'h0001;
      good(4);
      chk("t1_not_yet_locked", 32'(bus.o_locked), 0);
      good(1);
      chk("t1_locked_5th", 32'(bus.o_locked), 1);
      good(256);
      chk("t1_word_cnt", 32'(bus.o_word_cnt), 256);
      chk("t1_err_cnt", 32'(bus.o_err_cnt), 0);
      // single bit error: one pulse, flywheel keeps lock
      step(g ^ 16'h0001, 1'b1, 1'b0);
      g = f(g);
      chk("t2_pulse", 32'(bus.o_err_pulse), 1);
      good(1);
      chk("t2_pulse_gone", 32'(bus.o_err_pulse), 0);
      good(20);
      chk("t2_err_cnt", 32'(bus.o_err_cnt), 1);
      chk("t2_locked", 32'(bus.o_locked), 1);
      // eight bad words force resync, then relock after five
      step(16'h0, 1'b0, 1'b1);
      chk("t3_clr", 32'(bus.o_err_cnt), 0);
      for (int i = 0; i < 8; i++) begin
         step(16'h1234, 1'b1, 1'b0);
         g = f(g);
         if (i == 6) chk("t3_still_locked", 32'(bus.o_locked), 1);
      end
      chk("t3_unlocked", 32'(bus.o_locked), 0);
      chk("t3_err_cnt", 32'(bus.o_err_cnt), 8);
      good(4);
      chk("t3_relock_early", 32'(bus.o_locked), 0);
      good(1);
      chk("t3_relocked", 32'(bus.o_locked), 1);
      // zeros ignored in SEEK, mismatch in VERIFY reseeds
      do_reset();
      step(16'h0, 1'b1, 1'b0);
      step(16'h0, 1'b1, 1'b0);
      step(16'h0001, 1'b1, 1'b0);
      step(16'h0002, 1'b1, 1'b0);
      step(16'h0FFF, 1'b1, 1'b0);
      g = f(16'h0FFF);
      good(3);
      chk("t4_not_locked", 32'(bus.o_locked), 0);
      good(1);
      chk("t4_locked", 32'(bus.o_locked), 1);
      chk("t4_err_cnt", 32'(bus.o_err_cnt), 0);
      // gapped valid: lock counts valid words only; clr beats a same-edge error
      do_reset();
      g = 16'h0001;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) chk("t5_not_locked", 32'(bus.o_locked), 0);
         step(g, 1'b1, 1'b0);
         g = f(g);
         step(16'hDEAD, 1'b0, 1'b0);
      end
      chk("t5_locked", 32'(bus.o_locked), 1);
      good(3);
      step(g ^ 16'h8000, 1'b1, 1'b1);
      g = f(g);
      chk("t5_clr_err", 32'(bus.o_err_cnt), 0);
      chk("t5_clr_word", 32'(bus.o_word_cnt), 0);
      chk("t5_clr_pulse", 32'(bus.o_err_pulse), 1);
      // async reset mid-cycle while locked with errors
      for (int i = 0; i < 3; i++) begin step(~g, 1'b1, 1'b0); g = f(g); end
      chk("t6_err_cnt3", 32'(bus.o_err_cnt), 3);
      bus.i_data_valid = 1'b0;
      #2 resetn = 1'b0;
      #1;
      chk("t6_async_locked", 32'(bus.o_locked), 0);
      chk("t6_async_pulse", 32'(bus.o_err_pulse), 0);
      chk("t6_async_err", 32'(bus.o_err_cnt), 0);
      chk("t6_async_word", 32'(bus.o_word_cnt), 0);
      model_reset();
      #1 resetn = 1'b1;
      step(16'h0, 1'b0, 1'b0);
      g = 16'h0001;
      good(5);
      chk("t6_relock", 32'(bus.o_locked), 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
